// File: rtl/lab3_pkg.sv
// rtl/lab3_pkg.sv - shared types and constants for the lab 3 function-block tester
package lab3_pkg;

  localparam int          LAB3_VEC_W   = 4;
  localparam logic [15:0] LAB3_G_TRUTH = 16'hEF7C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } lab3_tst_state_t;

endpackage

// File: rtl/lab3_g_tester_if.sv
// rtl/lab3_g_tester_if.sv - tester control, drive vector and result bundle
interface lab3_g_tester_if;
  import lab3_pkg::*;

  logic                  CL2947MP_start;
  logic                  CL2947MP_dut_out;
  logic                  CL2947MP_w;
  logic                  CL2947MP_x;
  logic                  CL2947MP_y;
  logic                  CL2947MP_z;
  logic                  CL2947MP_busy;
  logic                  CL2947MP_done;
  logic                  CL2947MP_pass;
  logic [4:0]            CL2947MP_err_count;
  logic [15:0]           CL2947MP_fail_mask;
  logic [LAB3_VEC_W-1:0] CL2947MP_first_fail;
  logic                  CL2947MP_first_fail_vld;

  // master is the tester; slave is the board or bench hosting the function block
  modport master (
    input  CL2947MP_start, CL2947MP_dut_out,
    output CL2947MP_w, CL2947MP_x, CL2947MP_y, CL2947MP_z,
    output CL2947MP_busy, CL2947MP_done, CL2947MP_pass,
    output CL2947MP_err_count, CL2947MP_fail_mask,
    output CL2947MP_first_fail, CL2947MP_first_fail_vld
  );

  modport slave (
    output CL2947MP_start, CL2947MP_dut_out,
    input  CL2947MP_w, CL2947MP_x, CL2947MP_y, CL2947MP_z,
    input  CL2947MP_busy, CL2947MP_done, CL2947MP_pass,
    input  CL2947MP_err_count, CL2947MP_fail_mask,
    input  CL2947MP_first_fail, CL2947MP_first_fail_vld
  );

endinterface

// File: rtl/lab3_settle_timer.sv
// rtl/lab3_settle_timer.sv - 4-bit loadable down-counter timing each vector's settle window
module lab3_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       expire
);

  logic [3:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != 4'd0)) begin
      count_q <= count_q - 4'd1;
    end
  end

  // expiring on 1 rather than 0 leaves SETTLE cycles in APPLY
  assign expire = (count_q == 4'd1);

endmodule

// File: rtl/lab3_g_tester.sv
// rtl/lab3_g_tester.sv - walks all 16 inputs of lab3_g and scores its output against a truth table
module lab3_g_tester
  import lab3_pkg::*;
#(
  parameter logic [15:0] EXPECTED = LAB3_G_TRUTH,
  parameter int          SETTLE   = 2
) (
  input logic              CL2947MP_clk,
  input logic              CL2947MP_rst_n,
  lab3_g_tester_if.master  bus
);

  localparam logic [3:0] SETTLE_V = 4'(SETTLE);
  localparam logic [LAB3_VEC_W-1:0] LAST_IDX = '1;

  lab3_tst_state_t       state_q, state_d;
  logic [LAB3_VEC_W-1:0] index_q;
  logic [4:0]            err_count_q;
  logic [15:0]           fail_mask_q;
  logic [LAB3_VEC_W-1:0] first_fail_q;
  logic                  first_fail_vld_q;

  logic accept, check_en, tmr_load, tmr_en, expire, mismatch;
  logic busy, done;

  lab3_settle_timer u_timer (
    .clk      (CL2947MP_clk),
    .rst_n    (CL2947MP_rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (SETTLE_V),
    .expire   (expire)
  );

  always_ff @(posedge CL2947MP_clk or negedge CL2947MP_rst_n) begin
    if (!CL2947MP_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (bus.CL2947MP_start) state_d = ST_APPLY;
      ST_APPLY:         if (expire) state_d = ST_CHECK;
      ST_CHECK:         state_d = (index_q == LAST_IDX) ? ST_DONE : ST_APPLY;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept   = 1'b0;
    check_en = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        accept   = bus.CL2947MP_start;
        tmr_load = bus.CL2947MP_start;
      end
      ST_APPLY: begin
        busy   = 1'b1;
        tmr_en = 1'b1;
      end
      ST_CHECK: begin
        busy     = 1'b1;
        check_en = 1'b1;
        tmr_load = (index_q != LAST_IDX);
      end
      ST_DONE: begin
        done     = 1'b1;
        accept   = bus.CL2947MP_start;
        tmr_load = bus.CL2947MP_start;
      end
      default: ;
    endcase
  end

  assign mismatch = (bus.CL2947MP_dut_out != EXPECTED[index_q]);

  // scoreboard: cleared on an accepted start, updated only on the CHECK cycle
  always_ff @(posedge CL2947MP_clk or negedge CL2947MP_rst_n) begin
    if (!CL2947MP_rst_n) begin
      index_q          <= '0;
      err_count_q      <= 5'd0;
      fail_mask_q      <= 16'h0000;
      first_fail_q     <= '0;
      first_fail_vld_q <= 1'b0;
    end else if (accept) begin
      index_q          <= '0;
      err_count_q      <= 5'd0;
      fail_mask_q      <= 16'h0000;
      first_fail_q     <= '0;
      first_fail_vld_q <= 1'b0;
    end else if (check_en) begin
      if (mismatch) begin
        fail_mask_q[index_q] <= 1'b1;
        err_count_q          <= err_count_q + 5'd1;
        if (!first_fail_vld_q) begin
          first_fail_q     <= index_q;
          first_fail_vld_q <= 1'b1;
        end
      end
      if (index_q != LAST_IDX) begin
        index_q <= index_q + 1'b1;
      end
    end
  end

  assign bus.CL2947MP_w              = index_q[3];
  assign bus.CL2947MP_x              = index_q[2];
  assign bus.CL2947MP_y              = index_q[1];
  assign bus.CL2947MP_z              = index_q[0];
  assign bus.CL2947MP_busy           = busy;
  assign bus.CL2947MP_done           = done;
  assign bus.CL2947MP_pass           = done && (err_count_q == 5'd0);
  assign bus.CL2947MP_err_count      = err_count_q;
  assign bus.CL2947MP_fail_mask      = fail_mask_q;
  assign bus.CL2947MP_first_fail     = first_fail_q;
  assign bus.CL2947MP_first_fail_vld = first_fail_vld_q;

endmodule

// File: tb/tb_lab3_g_tester.sv
// tb/tb_lab3_g_tester.sv - directed bench for lab3_g_tester against good and faulty function blocks
module tb_lab3_g_tester;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       f_good;
  logic [3:0] vec;
  int         checks;
  int         errors;

  lab3_g_tester_if tif ();

  lab3_g_tester #(.EXPECTED(16'hEF7C), .SETTLE(2)) dut (
    .CL2947MP_clk   (clk),
    .CL2947MP_rst_n (rst_n),
    .bus            (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign vec = {tif.CL2947MP_w, tif.CL2947MP_x, tif.CL2947MP_y, tif.CL2947MP_z};

  // (wx')+(wz)+(w'xy')+(x'y)+(yz') written independently of the golden table
  assign f_good = (tif.CL2947MP_w & ~tif.CL2947MP_x) | (tif.CL2947MP_w & tif.CL2947MP_z) |
                  (~tif.CL2947MP_w & tif.CL2947MP_x & ~tif.CL2947MP_y) |
                  (~tif.CL2947MP_x & tif.CL2947MP_y) | (tif.CL2947MP_y & ~tif.CL2947MP_z);

  // mode 0 good, 1 inverted, 2 stuck at 0, 3 forced 1 at index 12 only
  assign tif.CL2947MP_dut_out = (mode == 2'd0) ? f_good :
                                (mode == 2'd1) ? ~f_good :
                                (mode == 2'd2) ? 1'b0 :
                                (f_good | (vec == 4'd12));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 tif.CL2947MP_start = 1'b1;
    @(posedge clk); #1 tif.CL2947MP_start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!tif.CL2947MP_done && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic check_results(input string tag, input logic [4:0] err, input logic [15:0] mask,
                               input logic [3:0] ff, input logic ffv, input logic pass);
    check({tag, "_err_count"}, 32'(tif.CL2947MP_err_count), 32'(err));
    check({tag, "_fail_mask"}, 32'(tif.CL2947MP_fail_mask), 32'(mask));
    check({tag, "_first_fail"}, 32'(tif.CL2947MP_first_fail), 32'(ff));
    check({tag, "_first_fail_vld"}, 32'(tif.CL2947MP_first_fail_vld), 32'(ffv));
    check({tag, "_pass"}, 32'(tif.CL2947MP_pass), 32'(pass));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(tif.CL2947MP_busy), 32'd0);
    check({tag, "_done"}, 32'(tif.CL2947MP_done), 32'd0);
    check({tag, "_vec"}, 32'(vec), 32'd0);
    check_results(tag, 5'd0, 16'h0000, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int cyc;
    int vec_errs;
    bit pulsed;
    checks = 0;
    errors = 0;
    mode   = 2'd0;
    rst_n  = 1'b0;
    tif.CL2947MP_start = 1'b0;

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // good block: done 48 edges after busy rises
    mode = 2'd0;
    pulse_start();
    check("good_busy", 32'(tif.CL2947MP_busy), 32'd1);
    wait_done(cyc);
    check("good_latency", 32'(cyc), 32'd48);
    check("good_busy_end", 32'(tif.CL2947MP_busy), 32'd0);
    check_results("good", 5'd0, 16'h0000, 4'd0, 1'b0, 1'b1);

    mode = 2'd1;
    pulse_start();
    wait_done(cyc);
    check("inv_latency", 32'(cyc), 32'd48);
    check_results("inv", 5'd16, 16'hFFFF, 4'd0, 1'b1, 1'b0);

    mode = 2'd2;
    pulse_start();
    wait_done(cyc);
    check_results("stuck0", 5'd12, 16'hEF7C, 4'd2, 1'b1, 1'b0);

    // re-pulse start mid-run at index 5; completion time must not move
    mode = 2'd0;
    pulse_start();
    cyc = 0;
    pulsed = 1'b0;
    while (!tif.CL2947MP_done && cyc < 200) begin
      if (!pulsed && vec == 4'd5) begin
        tif.CL2947MP_start = 1'b1;
        pulsed = 1'b1;
      end else begin
        tif.CL2947MP_start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    tif.CL2947MP_start = 1'b0;
    check("restart_pulsed", 32'(pulsed), 32'd1);
    check("restart_latency", 32'(cyc), 32'd48);
    check_results("restart", 5'd0, 16'h0000, 4'd0, 1'b0, 1'b1);

    // start from DONE clears results; then watch each vector held 3 cycles
    mode = 2'd3;
    pulse_start();
    check("redo_busy", 32'(tif.CL2947MP_busy), 32'd1);
    check("redo_done", 32'(tif.CL2947MP_done), 32'd0);
    check("redo_err_cleared", 32'(tif.CL2947MP_err_count), 32'd0);
    check("redo_vld_cleared", 32'(tif.CL2947MP_first_fail_vld), 32'd0);
    vec_errs = 0;
    for (int t = 0; t < 48; t++) begin
      if (vec !== 4'(t / 3)) vec_errs++;
      @(posedge clk); #1;
    end
    check("step_vectors", 32'(vec_errs), 32'd0);
    check("step_done", 32'(tif.CL2947MP_done), 32'd1);
    check_results("fault12", 5'd1, 16'h1000, 4'd12, 1'b1, 1'b0);

    // asynchronous abort at index 7
    mode = 2'd2;
    pulse_start();
    cyc = 0;
    while (vec != 4'd7 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reached7", 32'(vec), 32'd7);
    check("abort_has_errs", 32'(tif.CL2947MP_err_count != 5'd0), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk) rst_n = 1'b1;
    mode = 2'd0;
    pulse_start();
    wait_done(cyc);
    check("post_abort_latency", 32'(cyc), 32'd48);
    check_results("post_abort", 5'd0, 16'h0000, 4'd0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
